// File: rtl/poliriscv_pkg.sv
// Shared types and constants for the PoliRISC-V multicycle control unit.
package poliriscv_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD  = 2'b00,
    ALUOP_SUB  = 2'b01,
    ALUOP_FUNC = 2'b10
  } aluop_e;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALUOUT = 1'b1;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format depends only on the opcode, independent of FSM state.
  function automatic logic [1:0] imm_format(input logic [6:0] op);
    case (op)
      OP_SW:     return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/poliriscv_mc_ctrl_if.sv
// Control/datapath bundle: instruction fields in, mux selects and enables out.
interface poliriscv_mc_ctrl_if;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;

  logic       pcwrite;
  logic       adrsrc;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic [1:0] resultsrc;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic [1:0] immsrc;
  logic [3:0] alu_ctrl;
  logic       instr_done;
  logic       illegal;
  logic [3:0] state_o;

  // Datapath side: supplies instruction fields, consumes control.
  modport master (
    output opcode, funct3, funct7b5, zero,
    input  pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc,
           alusrca, alusrcb, immsrc, alu_ctrl, instr_done, illegal, state_o
  );

  modport slave (
    input  opcode, funct3, funct7b5, zero,
    output pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc,
           alusrca, alusrcb, immsrc, alu_ctrl, instr_done, illegal, state_o
  );

endinterface

// File: rtl/poliriscv_aludec.sv
// Combinational ALU decoder: fixed add/sub or function-decoded operation.
module poliriscv_aludec
  import poliriscv_pkg::*;
(
  input  aluop_e     aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [3:0] alu_ctrl
);

  logic bit3;

  // For I-type, instr[30] is immediate data except in srai.
  always_comb begin
    bit3 = op5 ? funct7b5 : (funct7b5 && (funct3 == 3'b101));
    case (aluop)
      ALUOP_SUB:  alu_ctrl = ALU_SUB;
      ALUOP_FUNC: alu_ctrl = {bit3, funct3};
      default:    alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/poliriscv_mc_ctrl.sv
// Multicycle Moore control FSM for PoliRISC-V.
// Define POLIRISCV_JAL_EN to add the JAL state; otherwise jal decodes as illegal.
module poliriscv_mc_ctrl
  import poliriscv_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = FETCH
) (
  input logic          clk,
  input logic          rst,
  poliriscv_mc_ctrl_if.slave bus
);

  localparam logic [3:0] S_FETCH    = FETCH;
  localparam logic [3:0] S_DECODE   = DECODE;
  localparam logic [3:0] S_MEMADR   = MEMADR;
  localparam logic [3:0] S_MEMREAD  = MEMREAD;
  localparam logic [3:0] S_MEMWB    = MEMWB;
  localparam logic [3:0] S_MEMWRITE = MEMWRITE;
  localparam logic [3:0] S_EXECR    = EXECR;
  localparam logic [3:0] S_EXECI    = EXECI;
  localparam logic [3:0] S_ALUWB    = ALUWB;
  localparam logic [3:0] S_BRANCH   = BRANCH;
`ifdef POLIRISCV_JAL_EN
  localparam logic [3:0] S_JAL      = JAL;
`endif

  logic [3:0] state;
  logic [3:0] state_next;
  logic       dec_illegal;
  logic       branch_taken;
  logic       pcwrite_raw;
  logic       memwrite_raw;
  logic       irwrite_raw;
  logic       regwrite_raw;
  logic       done_raw;
  logic       illegal_raw;
  logic       adrsrc;
  logic [1:0] resultsrc;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  aluop_e     aluop;
  logic [3:0] alu_ctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RESET_STATE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    case (bus.opcode)
      OP_LW, OP_SW, OP_R, OP_I, OP_BRANCH: dec_illegal = 1'b0;
`ifdef POLIRISCV_JAL_EN
      OP_JAL:                              dec_illegal = 1'b0;
`endif
      default:                             dec_illegal = 1'b1;
    endcase
  end

  assign branch_taken = ((bus.funct3 == 3'b000) &&  bus.zero) ||
                        ((bus.funct3 == 3'b001) && !bus.zero);

  // Every terminal state, and any unused encoding, falls back to FETCH.
  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECR;
          OP_I:         state_next = S_EXECI;
          OP_BRANCH:    state_next = S_BRANCH;
`ifdef POLIRISCV_JAL_EN
          OP_JAL:       state_next = S_JAL;
`endif
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR:         state_next = (bus.opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:        state_next = S_MEMWB;
      S_EXECR, S_EXECI: state_next = S_ALUWB;
`ifdef POLIRISCV_JAL_EN
      S_JAL:            state_next = S_ALUWB;
`endif
      default:          state_next = S_FETCH;
    endcase
  end

  always_comb begin
    pcwrite_raw  = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    done_raw     = 1'b0;
    illegal_raw  = 1'b0;
    adrsrc       = ADR_PC;
    resultsrc    = RES_ALUOUT;
    alusrca      = SRCA_PC;
    alusrcb      = SRCB_RS2;
    aluop        = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        adrsrc      = ADR_PC;
        irwrite_raw = 1'b1;
        alusrca     = SRCA_PC;
        alusrcb     = SRCB_FOUR;
        resultsrc   = RES_ALURESULT;
        pcwrite_raw = 1'b1;
      end
      S_DECODE: begin
        alusrca     = SRCA_OLDPC;
        alusrcb     = SRCB_IMM;
        illegal_raw = dec_illegal;
      end
      S_MEMADR: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_IMM;
      end
      S_MEMREAD: begin
        adrsrc    = ADR_ALUOUT;
        resultsrc = RES_ALUOUT;
      end
      S_MEMWB: begin
        resultsrc    = RES_MEMDATA;
        regwrite_raw = 1'b1;
        done_raw     = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc       = ADR_ALUOUT;
        memwrite_raw = 1'b1;
        done_raw     = 1'b1;
      end
      S_EXECR: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_RS2;
        aluop   = ALUOP_FUNC;
      end
      S_EXECI: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_IMM;
        aluop   = ALUOP_FUNC;
      end
      S_ALUWB: begin
        resultsrc    = RES_ALUOUT;
        regwrite_raw = 1'b1;
        done_raw     = 1'b1;
      end
      S_BRANCH: begin
        alusrca     = SRCA_RS1;
        alusrcb     = SRCB_RS2;
        aluop       = ALUOP_SUB;
        resultsrc   = RES_ALUOUT;
        pcwrite_raw = branch_taken;
        done_raw    = 1'b1;
      end
`ifdef POLIRISCV_JAL_EN
      // PC takes the target that DECODE left in ALUOut; ALUWB then links PC+4.
      S_JAL: begin
        alusrca     = SRCA_OLDPC;
        alusrcb     = SRCB_FOUR;
        resultsrc   = RES_ALUOUT;
        pcwrite_raw = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  poliriscv_aludec u_aludec (
    .aluop    (aluop),
    .funct3   (bus.funct3),
    .funct7b5 (bus.funct7b5),
    .op5      (bus.opcode[5]),
    .alu_ctrl (alu_ctrl)
  );

  // Reset gates every side-effecting enable so an abandoned instruction cannot write.
  assign bus.pcwrite    = pcwrite_raw  & ~rst;
  assign bus.memwrite   = memwrite_raw & ~rst;
  assign bus.irwrite    = irwrite_raw  & ~rst;
  assign bus.regwrite   = regwrite_raw & ~rst;
  assign bus.instr_done = done_raw     & ~rst;
  assign bus.illegal    = illegal_raw  & ~rst;
  assign bus.adrsrc     = adrsrc;
  assign bus.resultsrc  = resultsrc;
  assign bus.alusrca    = alusrca;
  assign bus.alusrcb    = alusrcb;
  assign bus.alu_ctrl   = alu_ctrl;
  assign bus.immsrc     = imm_format(bus.opcode);
  assign bus.state_o    = state;

endmodule

// File: tb/tb_poliriscv_mc_ctrl.sv
// Self-checking bench for poliriscv_mc_ctrl: directed cases plus random instruction mix.
module tb_poliriscv_mc_ctrl;
  import poliriscv_pkg::*;

  localparam logic [6:0] T_LW  = 7'b0000011;
  localparam logic [6:0] T_SW  = 7'b0100011;
  localparam logic [6:0] T_R   = 7'b0110011;
  localparam logic [6:0] T_I   = 7'b0010011;
  localparam logic [6:0] T_B   = 7'b1100011;
  localparam logic [6:0] T_JAL = 7'b1101111;

  typedef struct packed {
    logic       pcwrite;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] immsrc;
    logic [3:0] alu_ctrl;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

  logic clk = 1'b0;
  logic rst;
  int   check_count = 0;
  int   error_count = 0;

  poliriscv_mc_ctrl_if bus ();

  poliriscv_mc_ctrl #(.RESET_STATE(FETCH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic is_legal(input logic [6:0] op);
`ifdef POLIRISCV_JAL_EN
    if (op == T_JAL) return 1'b1;
`endif
    return (op == T_LW) || (op == T_SW) || (op == T_R) || (op == T_I) || (op == T_B);
  endfunction

  // Reference: what each step of an instruction must drive, from the ISA-level rules.
  function automatic ctrl_t expected_ctrl(input logic [3:0] st, input logic [6:0] op,
                                          input logic [2:0] f3, input logic f7,
                                          input logic z, input logic in_reset);
    ctrl_t c = '0;
    c.immsrc = (op == T_SW) ? 2'd1 : (op == T_B) ? 2'd2 : (op == T_JAL) ? 2'd3 : 2'd0;
    case (st)
      FETCH:    begin c.irwrite = 1; c.alusrcb = 2; c.resultsrc = 2; c.pcwrite = 1; end
      DECODE:   begin c.alusrca = 1; c.alusrcb = 1; c.illegal = !is_legal(op); end
      MEMADR:   begin c.alusrca = 2; c.alusrcb = 1; end
      MEMREAD:  begin c.adrsrc = 1; end
      MEMWB:    begin c.resultsrc = 1; c.regwrite = 1; c.instr_done = 1; end
      MEMWRITE: begin c.adrsrc = 1; c.memwrite = 1; c.instr_done = 1; end
      EXECR:    begin c.alusrca = 2; c.alu_ctrl = {f7, f3}; end
      EXECI:    begin c.alusrca = 2; c.alusrcb = 1; c.alu_ctrl = {f7 && (f3 == 3'd5), f3}; end
      ALUWB:    begin c.regwrite = 1; c.instr_done = 1; end
      BRANCH:   begin
        c.alusrca = 2; c.alu_ctrl = 4'b1000; c.instr_done = 1;
        c.pcwrite = ((f3 == 3'd0) && z) || ((f3 == 3'd1) && !z);
      end
      JAL:      begin c.alusrca = 1; c.alusrcb = 2; c.pcwrite = 1; end
      default:  ;
    endcase
    if (in_reset) begin
      c.pcwrite = 0; c.irwrite = 0; c.regwrite = 0; c.memwrite = 0; c.instr_done = 0; c.illegal = 0;
    end
    return c;
  endfunction

  function automatic logic [31:0] observed_ctrl();
    ctrl_t c;
    c = '{bus.pcwrite, bus.adrsrc, bus.memwrite, bus.irwrite, bus.regwrite, bus.resultsrc,
          bus.alusrca, bus.alusrcb, bus.immsrc, bus.alu_ctrl, bus.instr_done, bus.illegal};
    return {13'b0, c};
  endfunction

  // Runs one instruction starting in FETCH; zero_mode 0/1 holds zero, 2 randomises it.
  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic f7, input int zero_mode);
    logic [3:0] seq[$];
    int         done_seen = 0;
    int         ill_seen = 0;
    logic       z;
    bus.opcode   = op;
    bus.funct3   = f3;
    bus.funct7b5 = f7;
    if (!is_legal(op))    seq = '{FETCH, DECODE};
    else if (op == T_LW)  seq = '{FETCH, DECODE, MEMADR, MEMREAD, MEMWB};
    else if (op == T_SW)  seq = '{FETCH, DECODE, MEMADR, MEMWRITE};
    else if (op == T_R)   seq = '{FETCH, DECODE, EXECR, ALUWB};
    else if (op == T_I)   seq = '{FETCH, DECODE, EXECI, ALUWB};
    else if (op == T_B)   seq = '{FETCH, DECODE, BRANCH};
    else                  seq = '{FETCH, DECODE, JAL, ALUWB};
    foreach (seq[i]) begin
      z = (zero_mode == 2) ? 1'($urandom_range(0, 1)) : (zero_mode == 1);
      bus.zero = z;
      #1;
      checkOutput($sformatf("state op=%b f3=%0d step%0d", op, f3, i), {28'b0, bus.state_o}, {28'b0, seq[i]});
      checkOutput($sformatf("ctrl op=%b f3=%0d f7=%0d z=%0d step%0d", op, f3, f7, z, i),
                  observed_ctrl(), {13'b0, expected_ctrl(seq[i], op, f3, f7, z, 1'b0)});
      done_seen += int'(bus.instr_done);
      ill_seen  += int'(bus.illegal);
      @(negedge clk);
    end
    checkOutput($sformatf("done_pulses op=%b", op), done_seen, is_legal(op) ? 1 : 0);
    checkOutput($sformatf("illegal_pulses op=%b", op), ill_seen, is_legal(op) ? 0 : 1);
  endtask

  task automatic applyMidReset();
    logic [3:0] pre[3] = '{FETCH, DECODE, MEMADR};
    bus.opcode = T_SW;
    bus.funct3 = 3'b010;
    bus.zero   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("midrst state step%0d", i), {28'b0, bus.state_o}, {28'b0, pre[i]});
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    checkOutput("midrst state memwrite", {28'b0, bus.state_o}, {28'b0, MEMWRITE});
    checkOutput("midrst memwrite gated", {31'b0, bus.memwrite}, 32'd0);
    checkOutput("midrst ctrl", observed_ctrl(),
                {13'b0, expected_ctrl(MEMWRITE, T_SW, 3'b010, 1'b0, 1'b0, 1'b1)});
    @(negedge clk);
    #1;
    checkOutput("midrst state after edge", {28'b0, bus.state_o}, {28'b0, FETCH});
    checkOutput("midrst ctrl in reset", observed_ctrl(),
                {13'b0, expected_ctrl(FETCH, T_SW, 3'b010, 1'b0, 1'b0, 1'b1)});
    rst = 1'b0;
  endtask

  initial begin
    logic [6:0] op;
    logic [6:0] table_ops[6] = '{T_LW, T_SW, T_R, T_I, T_B, T_JAL};
    rst          = 1'b1;
    bus.opcode   = T_R;
    bus.funct3   = 3'b000;
    bus.funct7b5 = 1'b0;
    bus.zero     = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset state", {28'b0, bus.state_o}, {28'b0, FETCH});
    checkOutput("reset ctrl gated", observed_ctrl(),
                {13'b0, expected_ctrl(FETCH, T_R, 3'b000, 1'b0, 1'b0, 1'b1)});
    rst = 1'b0;

    applyStimulus(T_R, 3'b000, 1'b0, 0);
    applyStimulus(T_R, 3'b000, 1'b1, 0);
    applyStimulus(T_LW, 3'b010, 1'b0, 2);
    applyStimulus(T_SW, 3'b010, 1'b0, 2);
    applyStimulus(T_B, 3'b001, 1'b0, 0);
    applyStimulus(T_B, 3'b001, 1'b0, 1);
    applyStimulus(T_B, 3'b000, 1'b0, 0);
    applyStimulus(T_B, 3'b000, 1'b0, 1);
    applyStimulus(T_B, 3'b100, 1'b0, 1);
    applyStimulus(T_I, 3'b101, 1'b1, 0);
    applyStimulus(T_I, 3'b000, 1'b1, 0);
    applyStimulus(7'b1111111, 3'b000, 1'b0, 0);
    applyStimulus(T_JAL, 3'b000, 1'b0, 0);
    applyMidReset();
    applyStimulus(T_R, 3'b111, 1'b0, 2);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) op = 7'($urandom_range(0, 127));
      else op = table_ops[$urandom_range(0, 5)];
      applyStimulus(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2);
    end

    #1;
    checkOutput("final state", {28'b0, bus.state_o}, {28'b0, FETCH});
    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
